fetch_queue_unit: RTL and testbench

Parametrised next-generation instruction fetch stage. Holds the fetch PC and issues one request per cycle to an instruction memory that may insert wait states. Fetched {pc, instruction} pairs are buffered in a small FIFO and handed to decode over a valid/ready handshake. Branch-predictor redirects flush the FIFO and any in-flight response.

---
 rtl/fetch_queue_unit_pkg.sv | 15 +
 rtl/fetch_queue_unit_fifo.sv | 55 +++++
 rtl/fetch_queue_unit.sv | 94 +++++++++
 tb/tb_fetch_queue_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_unit_pkg.sv
// Shared defaults and the fetch-entry layout used by the fetch queue
// and by anything that inspects its entries.
package fetch_queue_unit_pkg;

  localparam int FQ_ADDR_W  = 16;
  localparam int FQ_INSTR_W = 16;

  localparam logic [FQ_INSTR_W-1:0] FQ_NOP_INSTR = '0;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0]  pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Small synchronous FIFO for fetched {pc, instr} entries. Clear has
// priority over push and pop; storage is not reset, only its bookkeeping.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !reset) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  a_count_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) (push && !clear) |-> !full);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) (pop && !clear) |-> !empty);

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one memory request per
// cycle, buffers responses in a small FIFO and presents the head to decode.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int                 ADDR_W    = FQ_ADDR_W,
  parameter int                 INSTR_W   = FQ_INSTR_W,
  parameter int                 DEPTH     = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(FQ_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  target_bp,
  input  logic               target_en_bp,
  output logic [ADDR_W-1:0]  next_program_counter_if_to_bp,
  output logic [ADDR_W-1:0]  address_to_memory,
  output logic               mem_req,
  input  logic [INSTR_W-1:0] data_from_memory,
  input  logic               mem_ready,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] instruction_if,
  output logic [ADDR_W-1:0]  pc_if,
  output logic [ADDR_W-1:0]  next_program_counter_if
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  entry_t            wr_entry;
  entry_t            head;

  // Request only when there is guaranteed room; a same-cycle pop is not
  // counted so that id_ready never reaches mem_req combinationally.
  assign mem_req = !reset && !fifo_full && !target_en_bp;
  assign accept  = mem_req && mem_ready;
  assign pop     = if_valid && id_ready && !target_en_bp;

  assign address_to_memory             = fetch_pc;
  assign next_program_counter_if_to_bp = fetch_pc + 1'b1;

  assign wr_entry.pc    = fetch_pc;
  assign wr_entry.instr = data_from_memory;

  always_ff @(posedge clk) begin
    if (reset)             fetch_pc <= RESET_PC;
    else if (target_en_bp) fetch_pc <= target_bp;
    else if (accept)       fetch_pc <= fetch_pc + 1'b1;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (target_en_bp),
    .push  (accept),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head mux: only FIFO storage feeds decode, never the memory bus.
  always_comb begin
    if_valid                = !fifo_empty;
    instruction_if          = NOP_INSTR;
    pc_if                   = '0;
    next_program_counter_if = '0;
    if (!fifo_empty) begin
      instruction_if          = head.instr;
      pc_if                   = head.pc;
      next_program_counter_if = head.pc + 1'b1;
    end
  end

  a_valid_matches_count: assert property (@(posedge clk) disable iff (reset)
    if_valid == (fifo_count != '0));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a queue-based model of the fetch
// stage checked every cycle, plus literal expectations at key points.
module tb_fetch_queue_unit;
  import fetch_queue_unit_pkg::*;

  localparam int DEPTH = 2;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] target_bp;
  logic        target_en_bp;
  logic        mem_ready;
  logic        id_ready;

  logic [15:0] bp_next, addr, instr, pc_if, next_pc;
  logic        mem_req, if_valid;
  logic [15:0] data_mem;

  logic [15:0] bp_next2, addr2, instr2, pc_if2, next_pc2;
  logic        mem_req2, if_valid2;
  logic [15:0] data_mem2;

  int checks = 0;
  int failures = 0;

  logic [15:0]  mpc;
  fetch_entry_t q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  assign data_mem  = mem_f(addr);
  assign data_mem2 = mem_f(addr2);

  fetch_queue_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH),
                     .RESET_PC(16'h0000), .NOP_INSTR(NOP)) u_dut (
    .clk(clk), .reset(reset), .target_bp(target_bp), .target_en_bp(target_en_bp),
    .next_program_counter_if_to_bp(bp_next), .address_to_memory(addr),
    .mem_req(mem_req), .data_from_memory(data_mem), .mem_ready(mem_ready),
    .if_valid(if_valid), .id_ready(id_ready), .instruction_if(instr),
    .pc_if(pc_if), .next_program_counter_if(next_pc));

  fetch_queue_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(DEPTH),
                     .RESET_PC(16'hFFFE), .NOP_INSTR(NOP)) u_dut_wrap (
    .clk(clk), .reset(reset), .target_bp(target_bp), .target_en_bp(target_en_bp),
    .next_program_counter_if_to_bp(bp_next2), .address_to_memory(addr2),
    .mem_req(mem_req2), .data_from_memory(data_mem2), .mem_ready(mem_ready),
    .if_valid(if_valid2), .id_ready(id_ready), .instruction_if(instr2),
    .pc_if(pc_if2), .next_program_counter_if(next_pc2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic compare();
    logic        exp_req;
    logic [15:0] h_instr, h_pc, h_next;
    exp_req = !reset && (q.size() < DEPTH) && !target_en_bp;
    h_instr = NOP; h_pc = 16'h0; h_next = 16'h0;
    if (q.size() != 0) begin
      h_instr = q[0].instr; h_pc = q[0].pc; h_next = q[0].pc + 16'h1;
    end
    chk("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    chk("address", {16'b0, addr}, {16'b0, mpc});
    chk("bp_next", {16'b0, bp_next}, {16'b0, 16'(mpc + 16'h1)});
    chk("if_valid", {31'b0, if_valid}, {31'b0, q.size() != 0});
    chk("instruction_if", {16'b0, instr}, {16'b0, h_instr});
    chk("pc_if", {16'b0, pc_if}, {16'b0, h_pc});
    chk("next_pc_if", {16'b0, next_pc}, {16'b0, h_next});
  endtask

  // Compare mid-cycle, advance the model by the rules, then cross the edge.
  task automatic step();
    logic req, do_pop, do_push;
    #2;
    compare();
    req = !reset && (q.size() < DEPTH) && !target_en_bp;
    if (reset) begin
      mpc = 16'h0000; q.delete();
    end else if (target_en_bp) begin
      mpc = target_bp; q.delete();
    end else begin
      do_pop  = (q.size() != 0) && id_ready;
      do_push = req && mem_ready;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back('{pc: mpc, instr: mem_f(mpc)});
        mpc = mpc + 16'h1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; target_bp = 16'h0; target_en_bp = 1'b0;
    mem_ready = 1'b1; id_ready = 1'b1;
    mpc = 16'h0000;
    @(posedge clk); #1;
    steps(2);
    chk("reset_valid", {31'b0, if_valid}, 32'd0);
    chk("reset_instr", {16'b0, instr}, 32'h0);
    chk("reset_addr_wrap", {16'b0, addr2}, 32'hFFFE);

    // Free run from reset.
    reset = 1'b0;
    #2;
    chk("first_req_valid_low", {31'b0, if_valid}, 32'd0);
    chk("first_req_mem_req", {31'b0, mem_req}, 32'd1);
    #1;
    step();
    chk("first_head_pc", {16'b0, pc_if}, 32'h0);
    chk("first_head_instr", {16'b0, instr}, 32'h1000);
    chk("first_head_next", {16'b0, next_pc}, 32'h1);
    chk("wrap_addr_1", {16'b0, addr2}, 32'hFFFF);
    chk("wrap_head_1", {16'b0, pc_if2}, 32'hFFFE);
    step();
    chk("wrap_addr_2", {16'b0, addr2}, 32'h0000);
    chk("wrap_head_2", {16'b0, pc_if2}, 32'hFFFF);
    chk("wrap_next_2", {16'b0, next_pc2}, 32'h0000);
    steps(4);

    // Decode stalls for 5 cycles from a fresh reset.
    reset = 1'b1; step(); reset = 1'b0;
    id_ready = 1'b0;
    steps(2);
    chk("stall_mem_req", {31'b0, mem_req}, 32'd0);
    chk("stall_addr", {16'b0, addr}, 32'h2);
    steps(3);
    id_ready = 1'b1;
    step();
    chk("stall_release_head", {16'b0, pc_if}, 32'h1);
    steps(3);

    // Wait states at PC 4.
    reset = 1'b1; step(); reset = 1'b0;
    steps(4);
    chk("ws_addr_start", {16'b0, addr}, 32'h4);
    mem_ready = 1'b0;
    steps(3);
    chk("ws_addr_held", {16'b0, addr}, 32'h4);
    chk("ws_drained", {31'b0, if_valid}, 32'd0);
    mem_ready = 1'b1;
    step();
    chk("ws_resume_head", {16'b0, pc_if}, 32'h4);
    step();
    chk("ws_resume_next", {16'b0, pc_if}, 32'h5);

    // Redirect with a full FIFO and a response on the bus.
    id_ready = 1'b0;
    steps(2);
    target_bp = 16'h0100; target_en_bp = 1'b1;
    step();
    target_en_bp = 1'b0;
    chk("redir_empty", {31'b0, if_valid}, 32'd0);
    chk("redir_addr", {16'b0, addr}, 32'h0100);
    id_ready = 1'b1;
    step();
    chk("redir_first_pc", {16'b0, pc_if}, 32'h0100);
    chk("redir_first_instr", {16'b0, instr}, 32'h1100);
    steps(2);

    // Redirect near the top of the address space, then a mixed pattern.
    target_bp = 16'hFFFE; target_en_bp = 1'b1; step(); target_en_bp = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem_ready = (i % 3) != 2;
      id_ready  = (i % 5) != 1;
      step();
    end

    // Reset mid-stream with full FIFO, stalled memory and a redirect.
    mem_ready = 1'b1; id_ready = 1'b0;
    steps(3);
    mem_ready = 1'b0;
    reset = 1'b1; target_bp = 16'h0200; target_en_bp = 1'b1;
    step();
    chk("midreset_valid", {31'b0, if_valid}, 32'd0);
    chk("midreset_instr", {16'b0, instr}, 32'h0);
    chk("midreset_addr", {16'b0, addr}, 32'h0);
    reset = 1'b0; target_en_bp = 1'b0; mem_ready = 1'b1; id_ready = 1'b1;
    steps(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
